// File: rtl/demux_1x7_stream.sv
// demux_1x7_stream: registered 1-to-7 stream demux with per-channel output registers and sel=7 drop counting
module demux_1x7_stream #(
  parameter int DATA_W = 8,
  parameter int ERR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic [2:0]        in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7*DATA_W-1:0] out_data,
  output logic [6:0]        out_valid,
  input  logic [6:0]        out_ready,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_cnt
);
  logic [7:0] free, xfer;
  // slot 7 is the discard destination and is always free
  assign free = {1'b1, ~out_valid | out_ready};
  assign in_ready = free[in_sel];
  assign xfer = (in_valid && in_ready) ? (8'd1 << in_sel) : 8'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= '0;
      out_data <= '0;
      err_pulse <= 1'b0;
      err_cnt <= '0;
    end else begin
      for (int k = 0; k < 7; k++) begin
        if (xfer[k]) out_data[k*DATA_W +: DATA_W] <= in_data;
        out_valid[k] <= xfer[k] | (out_valid[k] & ~out_ready[k]);
      end
      err_pulse <= xfer[7];
      if (xfer[7] && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
endmodule

// File: tb/tb_demux_1x7_stream.sv
// tb_demux_1x7_stream: directed and randomized checks against a per-channel queue model
module tb_demux_1x7_stream;
  logic clk = 0, rst_n = 0;
  logic [7:0] in_data = 0;
  logic [2:0] in_sel = 0;
  logic in_valid = 0, in_ready;
  logic [55:0] out_data;
  logic [6:0] out_valid, out_ready = '1;
  logic err_pulse;
  logic [7:0] err_cnt;
  int vectors = 0, miscompares = 0;
  logic [7:0] q[7][$];
  int drops = 0;
  bit exp_pulse = 0, stuck = 0;

  demux_1x7_stream dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .err_pulse(err_pulse), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ch(input int k);
    return out_data[k*8 +: 8];
  endfunction

  // compare current outputs against the model, then apply this cycle's handshakes to the model
  task automatic cyc();
    bit rdy;
    #1;
    rdy = in_sel == 3'd7 || q[in_sel].size() == 0 || out_ready[in_sel];
    chk("in_ready", in_ready, rdy);
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("valid%0d", k), out_valid[k], q[k].size() != 0);
      if (q[k].size() != 0) begin
        chk($sformatf("data%0d", k), ch(k), q[k][0]);
        if (out_ready[k]) void'(q[k].pop_front());
      end
    end
    chk("err_pulse", err_pulse, exp_pulse);
    chk("err_cnt", err_cnt, drops > 255 ? 255 : drops);
    exp_pulse = 0;
    stuck = in_valid && !rdy;
    if (in_valid && rdy) begin
      if (in_sel == 3'd7) begin
        drops++;
        exp_pulse = 1;
      end else q[in_sel].push_back(in_data);
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [2:0] s, input logic [7:0] d);
    in_valid = 1;
    in_sel = s;
    in_data = d;
    cyc();
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) cyc();
  endtask

  initial begin
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data[31:0], 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 7; k++) send(3'(k), 8'h10 + 8'(k));
    idle(2);
    chk("no_err", err_cnt, 0);
    out_ready = 7'h77;
    send(3, 8'hA5);
    in_sel = 3;
    in_data = 8'h5A;
    #1 chk("stall_ready", in_ready, 0);
    cyc();
    cyc();
    chk("stall_hold", ch(3), 8'hA5);
    out_ready = '1;
    cyc();
    chk("swap_valid", out_valid[3], 1);
    chk("swap_data", ch(3), 8'h5A);
    send(4, 8'h77);
    chk("ch4_valid", out_valid[4], 1);
    chk("ch4_data", ch(4), 8'h77);
    idle(1);
    for (int i = 0; i < 8; i++) begin
      send(2, 8'(i));
      chk("b2b_valid", out_valid[2], 1);
      chk("b2b_data", ch(2), 8'(i));
    end
    idle(1);
    repeat (3) send(7, 8'hEE);
    in_valid = 0;
    chk("err_first", err_pulse, 1);
    idle(2);
    chk("err3", err_cnt, 3);
    chk("err_novalid", out_valid, 0);
    repeat (260) send(7, 8'($urandom));
    idle(2);
    chk("err_sat", err_cnt, 255);
    out_ready = 0;
    send(0, 8'hC0);
    send(5, 8'hC5);
    send(6, 8'hC6);
    in_valid = 0;
    #3 rst_n = 0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_err", err_cnt, 0);
    chk("arst_ready", in_ready, 1);
    foreach (q[k]) q[k].delete();
    drops = 0;
    exp_pulse = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    out_ready = '1;
    in_valid = 1;
    in_sel = 5;
    in_data = 8'h55;
    #1 chk("post_rst_ready", in_ready, 1);
    cyc();
    chk("post_rst_data", ch(5), 8'h55);
    for (int i = 0; i < 10000; i++) begin
      if (!stuck) begin
        in_valid = $urandom_range(0, 9) < 7;
        in_sel = $urandom_range(0, 39) == 0 ? 3'd7 : 3'($urandom_range(0, 6));
        in_data = 8'($urandom);
      end
      out_ready = 7'($urandom);
      cyc();
    end
    in_valid = 0;
    out_ready = '1;
    idle(2);
    for (int k = 0; k < 7; k++) chk($sformatf("drained%0d", k), q[k].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/demux_1x7_stream.md
Name: demux_1x7_stream

Overview:
- Registered 1-to-7 stream demultiplexer, the distribution-side counterpart of the 7:1 select tree.
- Accepts one word per handshake, tagged with a 3-bit destination select, and delivers it to one of seven independent output channels.
- Each channel has its own single-entry output register and valid/ready handshake.
- Select code 7 has no destination. Words with that code are consumed, discarded and counted as errors.

Parameters:
- DATA_W, 8, width of the data word on the input and on each output channel.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  DATA_W  input word.
- in_sel  input  3  destination channel, 0..6; 7 is invalid.
- in_valid  input  1  input word and select are valid.
- in_ready  output  1  block can accept the input this cycle (combinational).
- out_data  output  7*DATA_W  channel k data on bits [k*DATA_W +: DATA_W].
- out_valid  output  7  per-channel valid, registered.
- out_ready  input  7  per-channel downstream ready.
- err_pulse  output  1  registered one-cycle pulse when a sel=7 word is discarded.
- err_cnt  output  ERR_W  saturating count of discarded words.

Behaviour:
- Reset: asynchronous assert on rst_n low. Clears all of the following:
  - out_valid = 0, out_data = 0.
  - err_pulse = 0, err_cnt = 0.
- Input acceptance, combinational:
  - Define ch_free[k] = !out_valid[k] | out_ready[k].
  - in_ready = 1 when in_sel == 7; otherwise in_ready = ch_free[in_sel].
  - in_ready does not depend on in_valid.
- Input transfer: occurs on a rising edge with in_valid & in_ready.
- Routing, valid select (0..6):
  - On transfer, out_data[in_sel] <= in_data and out_valid[in_sel] <= 1.
  - Latency: exactly 1 cycle from input transfer to out_valid.
  - Throughput: 1 word/cycle while the target channel is drained every cycle.
- Channel k pop: occurs when out_valid[k] & out_ready[k]. If no push to k happens in the same cycle, out_valid[k] <= 0. out_data[k] holds its last value (no clearing).
- Simultaneous pop and push on the same channel: the new word is loaded and out_valid[k] stays 1. No bubble, no loss.
- Stall: while out_valid[k] & !out_ready[k], out_data[k] and out_valid[k] must be held stable. An input targeting k sees in_ready = 0.
- Channel independence:
  - Only the channel addressed by in_sel is affected by a transfer.
  - Stalled channels never block transfers to other channels.
  - Pops on non-addressed channels proceed in the same cycle.
- Invalid select (7):
  - The word is accepted and dropped; no out_valid changes.
  - err_pulse <= 1 for the following cycle.
  - err_cnt <= err_cnt + 1, saturating at 2^ERR_W - 1 with no wrap.
- err_pulse is 0 in every cycle not following a dropped word.
- in_valid low: no state change except pops.
- Ordering: words to the same channel are delivered in acceptance order. No ordering guarantee is made across channels.
- Upstream contract: in_data and in_sel must stay stable while in_valid & !in_ready. The block does not check this.
- Reset mid-operation:
  - All pending channel words are lost and err_cnt clears immediately.
  - in_ready follows the combinational rule with out_valid = 0, so it is 1 during reset.
  - Nothing is captured while rst_n is low.
- No X propagation: out_data of a never-written channel reads 0.

Test Plan:
- Reset, then send sel 0..6 with data 0x10..0x16, all out_ready = 1 → out_valid[k] pulses one cycle after each transfer with out_data[k] = 0x10+k. in_ready stays 1 throughout. err_cnt = 0.
- Hold out_ready[3] = 0 and send 0xA5 to ch3, then 0x5A to ch3 and 0x77 to ch4:
  - ch3 holds 0xA5 and in_ready = 0 for the second ch3 word.
  - Raise out_ready[3]: 0xA5 pops and 0x5A loads in the same cycle, with out_valid[3] continuously 1.
  - The 0x77 word to ch4 is presented after the ch3 stall resolves, because the stalled ch3 word blocks the single input stream. Once presented it is accepted immediately and delivered 1 cycle later, despite ch3 having been stalled.
- Back-to-back to ch2 with out_ready[2] = 1 for 8 cycles, data 0..7 → 8 consecutive accepts, out_data[2] sequence 0..7 at 1 word/cycle, no bubbles.
- Send 3 words with sel = 7 → 3 single-cycle err_pulses, err_cnt = 3, all out_valid stay 0. Then force 260 invalid words with ERR_W = 8 → err_cnt saturates at 255.
- With ch0, ch5 and ch6 loaded and stalled, assert rst_n = 0 asynchronously mid-cycle → out_valid = 0 immediately, err_cnt = 0. After release, a word to ch5 is accepted in the first cycle.
- Randomised sel/valid/out_ready for 10k cycles against a per-channel FIFO scoreboard → every valid-sel word delivered exactly once and in order per channel; dropped count equals err_cnt (below saturation).
